// File: rtl/uart_rx_framed_if.sv
// Receive-side handshake bundle: head-of-FIFO word with status flags, valid/ready, overrun pulse.
`timescale 1ns/1ps
interface uart_rx_framed_if #(
  parameter int DATA_BITS = 8
);
  logic                 ready_in;
  logic                 valid_out;
  logic [DATA_BITS-1:0] data_out;
  logic                 parity_err_out;
  logic                 frame_err_out;
  logic                 break_out;
  logic                 overrun_out;

  modport master (
    input  ready_in,
    output valid_out, data_out, parity_err_out, frame_err_out, break_out, overrun_out
  );

  modport slave (
    output ready_in,
    input  valid_out, data_out, parity_err_out, frame_err_out, break_out, overrun_out
  );
endinterface

// File: rtl/uart_rx_framed.sv
// Parametrised UART receiver: mid-bit 3-sample majority vote, parity/framing/break detection,
// and a small FIFO of {break, frame_err, parity_err, data} words behind a valid/ready port.
`timescale 1ns/1ps
module uart_rx_framed #(
  parameter int INPUT_CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE        = 9600,
  parameter int DATA_BITS        = 8,
  parameter int PARITY           = 0,
  parameter int STOP_BITS        = 1,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             rx_wire_in,
  uart_rx_framed_if.master rx_if
);

  localparam int PERIOD = INPUT_CLOCK_FREQ / BAUD_RATE;
  localparam int H      = PERIOD / 2;
  localparam int CNT_W  = $clog2(PERIOD + 1);
  localparam int BI_W   = $clog2(DATA_BITS + 1);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int PW     = AW + 1;
  localparam int EW     = DATA_BITS + 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BRK
  } state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync1_d;
  logic                 rx_s_q, rx_s_d;
  logic                 rx_prev_q, rx_prev_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 samp_a_q, samp_a_d;
  logic                 samp_b_q, samp_b_d;
  logic [BI_W-1:0]      bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bit_q, par_bit_d;
  logic                 stop1_q, stop1_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [PW-1:0]        wptr_q, wptr_d;
  logic [PW-1:0]        rptr_q, rptr_d;
  logic [EW-1:0]        mem_q [FIFO_DEPTH];
  logic [EW-1:0]        mem_d [FIFO_DEPTH];
  logic                 overrun_q, overrun_d;

  logic          vote, at_vote, bit_end, last_stop, commit, first_stop;
  logic          brk, frame_err, parity_err;
  logic          empty, full, pop, push;
  logic [EW-1:0] entry, head;

  // State register (all sequential state, asynchronous reset)
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= S_IDLE;
      sync1_q    <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_prev_q  <= 1'b1;
      cnt_q      <= '0;
      samp_a_q   <= 1'b1;
      samp_b_q   <= 1'b1;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      stop1_q    <= 1'b1;
      stop_idx_q <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      mem_q      <= '{default: '0};
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      rx_s_q     <= rx_s_d;
      rx_prev_q  <= rx_prev_d;
      cnt_q      <= cnt_d;
      samp_a_q   <= samp_a_d;
      samp_b_q   <= samp_b_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      par_bit_q  <= par_bit_d;
      stop1_q    <= stop1_d;
      stop_idx_q <= stop_idx_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      mem_q      <= mem_d;
      overrun_q  <= overrun_d;
    end
  end

  // Bit-timing decode and frame status as seen at the final stop-bit vote
  always_comb begin
    vote       = (samp_a_q & samp_b_q) | (samp_a_q & rx_s_q) | (samp_b_q & rx_s_q);
    at_vote    = (cnt_q == CNT_W'(H + 1));
    bit_end    = (cnt_q == CNT_W'(PERIOD - 1));
    last_stop  = (stop_idx_q == 1'(STOP_BITS - 1));
    commit     = (state_q == S_STOP) && at_vote && last_stop;
    first_stop = (stop_idx_q == 1'b0) ? vote : stop1_q;
    brk        = (shift_q == '0) && ((PARITY == 0) || !par_bit_q) && !first_stop;
    frame_err  = !first_stop || !vote;
    parity_err = (PARITY != 0) && ((^shift_q ^ par_bit_q) != (PARITY == 1));
    entry      = {brk, frame_err, parity_err, shift_q};
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (rx_prev_q && !rx_s_q) state_d = S_START;
      S_START: begin
        if (at_vote && vote) state_d = S_IDLE;
        else if (bit_end)    state_d = S_DATA;
      end
      S_DATA:   if (bit_end && (bit_idx_q == BI_W'(DATA_BITS)))
                  state_d = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (bit_end) state_d = S_STOP;
      S_STOP:   if (commit) state_d = brk ? S_BRK : S_IDLE;
      S_BRK:    if (rx_s_q) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath: synchronizer, bit counter, samplers, shift register, FIFO
  always_comb begin
    sync1_d    = rx_wire_in;
    rx_s_d     = sync1_q;
    rx_prev_d  = rx_s_q;
    cnt_d      = ((state_q == S_IDLE) || (state_q == S_BRK) || bit_end) ? '0 : cnt_q + CNT_W'(1);
    samp_a_d   = (cnt_q == CNT_W'(H - 1)) ? rx_s_q : samp_a_q;
    samp_b_d   = (cnt_q == CNT_W'(H))     ? rx_s_q : samp_b_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    par_bit_d  = par_bit_q;
    stop1_d    = stop1_q;
    stop_idx_d = stop_idx_q;

    unique case (state_q)
      S_IDLE: begin
        bit_idx_d  = '0;
        stop_idx_d = 1'b0;
      end
      S_START: bit_idx_d = '0;
      S_DATA: if (at_vote) begin
        shift_d   = {vote, shift_q[DATA_BITS-1:1]};
        bit_idx_d = bit_idx_q + BI_W'(1);
      end
      S_PARITY: if (at_vote) par_bit_d = vote;
      S_STOP: begin
        if (at_vote && (stop_idx_q == 1'b0)) stop1_d = vote;
        if (bit_end) stop_idx_d = 1'b1;
      end
      default: ;
    endcase

    empty = (wptr_q == rptr_q);
    full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    pop   = !empty && rx_if.ready_in;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the commit
    push      = commit && (!full || pop);
    overrun_d = commit && full && !pop;
    wptr_d    = wptr_q + (push ? PW'(1) : '0);
    rptr_d    = rptr_q + (pop  ? PW'(1) : '0);
    mem_d     = mem_q;
    if (push) mem_d[wptr_q[AW-1:0]] = entry;
  end

  // Output logic: registered FIFO head and overrun pulse
  always_comb begin
    head                 = mem_q[rptr_q[AW-1:0]];
    rx_if.valid_out      = !empty;
    rx_if.data_out       = head[DATA_BITS-1:0];
    rx_if.parity_err_out = head[DATA_BITS];
    rx_if.frame_err_out  = head[DATA_BITS+1];
    rx_if.break_out      = head[DATA_BITS+2];
    rx_if.overrun_out    = overrun_q;
  end

endmodule

// File: tb/tb_uart_rx_framed.sv
// Directed bench for uart_rx_framed: three instances (8N1, 8E1, 8N2) at PERIOD=10 share one
// routed serial line; popped words are tagged by instance and compared with hand-computed values.
`timescale 1ns/1ps
module tb_uart_rx_framed;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int P      = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rx_line;
  int   cur_sel;
  logic rx_n1, rx_e1, rx_n2;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   ovr_cnt = 0;
  int   ovr_other = 0;
  logic [12:0] popq[$];

  assign rx_n1 = (cur_sel == 0) ? rx_line : 1'b1;
  assign rx_e1 = (cur_sel == 1) ? rx_line : 1'b1;
  assign rx_n2 = (cur_sel == 2) ? rx_line : 1'b1;

  uart_rx_framed_if #(.DATA_BITS(8)) if_n1 ();
  uart_rx_framed_if #(.DATA_BITS(8)) if_e1 ();
  uart_rx_framed_if #(.DATA_BITS(8)) if_n2 ();

  uart_rx_framed #(.INPUT_CLOCK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8),
                   .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_n1 (
    .clk_in(clk), .rst_n_in(rst_n), .rx_wire_in(rx_n1), .rx_if(if_n1));
  uart_rx_framed #(.INPUT_CLOCK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8),
                   .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_e1 (
    .clk_in(clk), .rst_n_in(rst_n), .rx_wire_in(rx_e1), .rx_if(if_e1));
  uart_rx_framed #(.INPUT_CLOCK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8),
                   .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_n2 (
    .clk_in(clk), .rst_n_in(rst_n), .rx_wire_in(rx_n2), .rx_if(if_n2));

  always @(posedge clk) cyc <= cyc + 1;

  // Word layout: {instance[1:0], break, frame_err, parity_err, data[7:0]}
  always @(negedge clk) begin
    if (if_n1.valid_out && if_n1.ready_in)
      popq.push_back({2'd0, if_n1.break_out, if_n1.frame_err_out, if_n1.parity_err_out, if_n1.data_out});
    if (if_e1.valid_out && if_e1.ready_in)
      popq.push_back({2'd1, if_e1.break_out, if_e1.frame_err_out, if_e1.parity_err_out, if_e1.data_out});
    if (if_n2.valid_out && if_n2.ready_in)
      popq.push_back({2'd2, if_n2.break_out, if_n2.frame_err_out, if_n2.parity_err_out, if_n2.data_out});
    if (if_n1.overrun_out) ovr_cnt++;
    if (if_e1.overrun_out || if_n2.overrun_out) ovr_other++;
  end

  typedef struct {
    int         sel;
    logic [7:0] data;
    logic       par;
    logic       s1;
    logic       s2;
    logic       exp_pe;
    logic       exp_fe;
    logic       exp_brk;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input int sel, input logic [7:0] d, input logic par,
                            input logic s1, input logic s2, input int gbit, input int goff);
    logic [11:0] bits;
    int n;
    cur_sel = sel;
    bits    = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    n = 9;
    if (sel == 1) begin bits[n] = par; n++; end
    bits[n] = s1; n++;
    if (sel == 2) begin bits[n] = s2; n++; end
    for (int b = 0; b < n; b++)
      for (int c = 0; c < P; c++) begin
        rx_line = (b == gbit && c == goff) ? ~bits[b] : bits[b];
        @(negedge clk);
      end
    rx_line = 1'b1;
  endtask

  task automatic expect_entry(input string name, input logic [12:0] exp);
    int k = 0;
    while (popq.size() == 0 && k < 4 * P) begin
      @(negedge clk);
      k++;
    end
    if (popq.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: no entry within %0d cycles, expected 0x%0h", name, 4 * P, exp);
    end else begin
      chk(name, 32'(popq.pop_front()), 32'(exp));
    end
  endtask

  task automatic set_ready_n1(input logic v);
    @(posedge clk);
    #1 if_n1.ready_in = v;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [7:0] ob [5];
    vecs[0]  = '{0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{0, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{0, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1, 8'h07, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1, 8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1, 8'h81, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{2, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{2, 8'hC3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{2, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[12] = '{0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[13] = '{1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    rst_n   = 1'b0;
    rx_line = 1'b1;
    cur_sel = 0;
    if_n1.ready_in = 1'b1;
    if_e1.ready_in = 1'b1;
    if_n2.ready_in = 1'b1;
    repeat (3) @(negedge clk);

    chk("reset_n1", {if_n1.valid_out, if_n1.break_out, if_n1.frame_err_out, if_n1.parity_err_out,
                     if_n1.overrun_out, if_n1.data_out}, '0);
    chk("reset_e1", {if_e1.valid_out, if_e1.break_out, if_e1.frame_err_out, if_e1.parity_err_out,
                     if_e1.overrun_out, if_e1.data_out}, '0);
    chk("reset_n2", {if_n2.valid_out, if_n2.break_out, if_n2.frame_err_out, if_n2.parity_err_out,
                     if_n2.overrun_out, if_n2.data_out}, '0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      send_frame(vecs[i].sel, vecs[i].data, vecs[i].par, vecs[i].s1, vecs[i].s2, -1, 0);
      expect_entry($sformatf("vec%0d", i),
                   {2'(vecs[i].sel), vecs[i].exp_brk, vecs[i].exp_fe, vecs[i].exp_pe, vecs[i].data});
      repeat (2 * P) @(negedge clk);
      chk($sformatf("vec%0d_extra", i), popq.size(), 0);
    end

    // Start-edge to valid_out latency, counted from the first clock edge that sees the low line
    lat = -1;
    fork
      send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b1, -1, 0);
      begin
        int t0;
        t0 = cyc + 1;
        for (int k = 0; k < 150; k++) begin
          @(negedge clk);
          if (if_n1.valid_out) begin
            lat = cyc - t0;
            break;
          end
        end
      end
    join
    n_tests++;
    if (!(lat >= 90 && lat <= 99)) begin
      n_fail++;
      $display("FAIL latency: got %0d cycles, required 90..99", lat);
    end
    expect_entry("latency_word", {2'd0, 3'b000, 8'hA5});
    repeat (2 * P) @(negedge clk);

    // Back-to-back frames with zero idle time
    send_frame(0, 8'h12, 1'b0, 1'b1, 1'b1, -1, 0);
    send_frame(0, 8'h34, 1'b0, 1'b1, 1'b1, -1, 0);
    expect_entry("b2b_n1_a", {2'd0, 3'b000, 8'h12});
    expect_entry("b2b_n1_b", {2'd0, 3'b000, 8'h34});
    send_frame(2, 8'h3C, 1'b0, 1'b0, 1'b1, -1, 0);
    send_frame(2, 8'h55, 1'b0, 1'b1, 1'b1, -1, 0);
    expect_entry("b2b_n2_a", {2'd2, 3'b010, 8'h3C});
    expect_entry("b2b_n2_b", {2'd2, 3'b000, 8'h55});
    repeat (2 * P) @(negedge clk);

    // Line break: 30 bit-times low gives exactly one break word
    cur_sel = 0;
    rx_line = 1'b0;
    repeat (30 * P) @(negedge clk);
    rx_line = 1'b1;
    repeat (2 * P) @(negedge clk);
    expect_entry("break_word", {2'd0, 3'b110, 8'h00});
    repeat (3 * P) @(negedge clk);
    chk("break_no_more", popq.size(), 0);

    // Short low glitch on idle line is a false start
    rx_line = 1'b0;
    repeat (3) @(negedge clk);
    rx_line = 1'b1;
    repeat (3 * P) @(negedge clk);
    chk("glitch_low_none", popq.size(), 0);

    // One-cycle inversions at data-bit centres are outvoted
    send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b1, 2, 6);
    expect_entry("glitch_bit1", {2'd0, 3'b000, 8'hA5});
    send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b1, 3, 6);
    expect_entry("glitch_bit2", {2'd0, 3'b000, 8'hA5});
    repeat (2 * P) @(negedge clk);

    // Overrun: ready low, five frames into a four-deep FIFO
    ob[0] = 8'h11; ob[1] = 8'h22; ob[2] = 8'h33; ob[3] = 8'h44; ob[4] = 8'h55;
    set_ready_n1(1'b0);
    ovr_cnt = 0;
    for (int i = 0; i < 4; i++) send_frame(0, ob[i], 1'b0, 1'b1, 1'b1, -1, 0);
    chk("ovr_before_5th", ovr_cnt, 0);
    chk("full_head", if_n1.data_out, 8'h11);
    send_frame(0, ob[4], 1'b0, 1'b1, 1'b1, -1, 0);
    repeat (P) @(negedge clk);
    chk("ovr_pulses", ovr_cnt, 1);
    chk("ovr_head", {if_n1.valid_out, if_n1.data_out}, {1'b1, 8'h11});
    chk("ovr_no_pops", popq.size(), 0);
    set_ready_n1(1'b1);
    repeat (8) @(negedge clk);
    for (int i = 0; i < 4; i++)
      expect_entry($sformatf("ovr_drain%0d", i), {2'd0, 3'b000, ob[i]});
    chk("ovr_drain_extra", popq.size(), 0);

    // Reset mid-frame with a word already buffered
    set_ready_n1(1'b0);
    send_frame(0, 8'h81, 1'b0, 1'b1, 1'b1, -1, 0);
    repeat (2) @(negedge clk);
    chk("prerst_head", {if_n1.valid_out, if_n1.data_out}, {1'b1, 8'h81});
    rx_line = 1'b0;
    repeat (3 * P + 3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {if_n1.valid_out, if_n1.break_out, if_n1.frame_err_out,
                            if_n1.parity_err_out, if_n1.overrun_out, if_n1.data_out}, '0);
    @(negedge clk);
    rx_line = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * P) @(negedge clk);
    set_ready_n1(1'b1);
    chk("rst_no_stale", popq.size(), 0);
    send_frame(0, 8'h5A, 1'b0, 1'b1, 1'b1, -1, 0);
    expect_entry("post_rst_word", {2'd0, 3'b000, 8'h5A});
    repeat (2 * P) @(negedge clk);
    chk("post_rst_extra", popq.size(), 0);
    chk("ovr_other_dut", ovr_other, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_framed.md
# uart_rx_framed

Parametrised UART receiver that succeeds the fixed 8N1 receiver. It supports configurable data width, parity mode and stop-bit count, and uses 3-sample majority voting at mid-bit. It checks framing and parity, detects line break, and buffers received words in a small FIFO with a valid/ready output. It sits between the board RX pin and the command parser, so bytes are not lost while the parser is busy.

## Interface
- INPUT_CLOCK_FREQ, 100_000_000: clk_in frequency in Hz.
- BAUD_RATE, 9600: line rate. PERIOD = INPUT_CLOCK_FREQ/BAUD_RATE (integer floor). PERIOD must be ≥ 8.
- DATA_BITS, 8: data bits per frame, legal range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: entries, power of two, ≥ 2.

Ports:
- clk_in, input, 1: single clock.
- rst_n_in, input, 1: asynchronous, active-low reset.
- rx_wire_in, input, 1: asynchronous serial line, idle high.
- ready_in, input, 1: consumer accepts the head entry when it is high together with valid_out.
- valid_out, output, 1: FIFO non-empty.
- data_out, output, DATA_BITS: head entry data, LSB = first bit received.
- parity_err_out, output, 1: head entry status, qualified by valid_out.
- frame_err_out, output, 1: head entry status, qualified by valid_out.
- break_out, output, 1: head entry status, qualified by valid_out.
- overrun_out, output, 1: one-cycle pulse when a completed frame is dropped because the FIFO is full.

## Operation
- rx_wire_in passes through a 2-flop synchronizer, reset to 1. All logic uses the synchronized signal rx_s.
- Bit counter counts clk_in cycles within a bit, 0..PERIOD-1. Width is $clog2(PERIOD+1).
- Bit value is the majority of rx_s sampled at counts H-1, H and H+1, where H = PERIOD/2.
- FSM states and transitions:
  - IDLE: a falling edge on rx_s (previous 1, current 0) goes to START and clears the counter.
  - START: at the vote, result 1 is a false start and returns to IDLE with nothing pushed. Result 0 goes to DATA at the bit boundary.
  - DATA: shifts in DATA_BITS voted bits, LSB first. Then goes to PARITY if PARITY≠0, else STOP.
  - PARITY: parity_err = (XOR of data bits ^ voted parity bit) != (PARITY==1). Odd mode requires the data bits plus the parity bit to have odd total ones.
  - STOP: the first stop bit is voted. When STOP_BITS=2 the second is also voted, and a 0 in either sets frame_err.
  - Commit happens at the H+1 sample of the last stop bit, not at the bit end. Commit returns to IDLE, or to BRK if break is set.
  - BRK: waits for rx_s = 1 before returning to IDLE. No further frames are detected until then.
- Break is set when all data bits, the parity bit (if present) and the first stop bit are 0. Break implies frame_err=1. parity_err is reported as computed.
- FIFO entry is {break, frame_err, parity_err, data}. Errored frames are still pushed.
- Push on commit. Pop when valid_out & ready_in.
- If the FIFO is full at commit with no simultaneous pop, the frame is dropped and overrun_out pulses for 1 cycle. The FIFO contents are unchanged.
- If the FIFO is full and a pop occurs in the same cycle, the push succeeds and there is no overrun.
- Push and pop in the same cycle when the FIFO is empty: the pop is ignored because valid_out is 0. The entry appears next cycle.
- Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally. Full/empty is decided by MSB comparison.

## Timing
- Reset values: valid_out=0, data_out=0, parity_err_out=0, frame_err_out=0, break_out=0, overrun_out=0. FSM=IDLE, FIFO empty, synchronizer=1.
- Assertion of rst_n_in mid-frame aborts the frame immediately (asynchronously). After release the receiver waits for a new falling edge.
- Line falling edge to START: 2 cycles of synchronizer delay plus 1 cycle of edge detection.
- Commit to valid_out high: 1 cycle when the FIFO was empty. Output fields are registered FIFO head and change only on pop or on push-into-empty.
- A start bit detected at the first stop bit's end is legal: back-to-back frames are supported with zero idle time.
- overrun_out is registered and asserts the cycle after the dropped commit.

## Test plan
Bench settings: INPUT_CLOCK_FREQ=1_000_000, BAUD_RATE=100_000 (PERIOD=10), ready_in=1 unless noted.
- 8N1, send 0xA5 -> one pop with data_out=0xA5 and all flags 0. valid_out rises within PERIOD·9.5+4 cycles of the start edge.
- 8E1, send 0x07 with parity bit 0 -> data_out=0x07, parity_err_out=1. The same byte with parity bit 1 -> parity_err_out=0.
- 8N2, send 0x3C with second stop bit 0 -> frame_err_out=1, data 0x3C. The next frame sent back-to-back, 0x55, is received clean.
- Line held low for 30 bit-times, then released -> exactly one entry: break_out=1, frame_err_out=1, data 0x00. Nothing further until a new start edge.
- ready_in=0, send 5 frames with FIFO_DEPTH=4 -> overrun_out pulses once at the 5th commit. Then ready_in=1 yields the first 4 bytes in order.
- Low glitch of 3 cycles on an idle line -> no entry. A 1-cycle high glitch at a data-bit centre -> correct byte via majority. rst_n_in low mid-frame -> all outputs 0, and the next full frame is received correctly.
